// File: rtl/lm32_itlb_assoc_pkg.sv
// Shared constants for the set-associative instruction TLB: CSR indices,
// maintenance command codes, FSM state encoding and operation kinds.
package lm32_itlb_assoc_pkg;

  localparam logic [4:0] TLB_VADDRESS = 5'h10;
  localparam logic [4:0] TLB_PADDRESS = 5'h11;

  localparam logic [2:0] CMD_FLUSH      = 3'b001;
  localparam logic [2:0] CMD_INVALIDATE = 3'b010;
  localparam logic [2:0] CMD_ASID_FLUSH = 3'b011;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FLUSH = 2'd1,
    ST_RD    = 2'd2,
    ST_WR    = 2'd3
  } itlb_state_t;

  typedef enum logic [1:0] {
    OP_UPDATE     = 2'd0,
    OP_INVALIDATE = 2'd1,
    OP_ASID_FLUSH = 2'd2
  } itlb_op_t;

endpackage

// File: rtl/lm32_itlb_way.sv
// One TLB way: a synchronous-read entry RAM plus the tag/ASID comparator
// applied to the entry read on the previous clock.
module lm32_itlb_way #(
  parameter int sets   = 64,
  parameter int idx_w  = 6,
  parameter int tag_w  = 14,
  parameter int asid_w = 8,
  parameter int pfn_w  = 20
) (
  input  logic              clk_i,
  input  logic [idx_w-1:0]  raddr,
  input  logic              we,
  input  logic [idx_w-1:0]  waddr,
  input  logic              wvalid,
  input  logic [asid_w-1:0] wasid,
  input  logic [tag_w-1:0]  wtag,
  input  logic [pfn_w-1:0]  wpfn,
  input  logic [tag_w-1:0]  cmp_tag,
  input  logic [asid_w-1:0] cmp_asid,
  output logic              rd_valid,
  output logic [pfn_w-1:0]  rd_pfn,
  output logic              hit,
  output logic              asid_hit
);

  localparam int ew = 1 + asid_w + tag_w + pfn_w;

  logic [ew-1:0]     mem [sets];
  logic [ew-1:0]     rdata_q;
  logic [asid_w-1:0] rd_asid;
  logic [tag_w-1:0]  rd_tag;

  // Entry store: one write port, one registered read port (old data on collision)
  always_ff @(posedge clk_i) begin
    if (we) mem[waddr] <= {wvalid, wasid, wtag, wpfn};
    rdata_q <= mem[raddr];
  end

  assign {rd_valid, rd_asid, rd_tag, rd_pfn} = rdata_q;
  assign hit      = rd_valid && (rd_tag == cmp_tag) && (rd_asid == cmp_asid);
  assign asid_hit = rd_valid && (rd_asid == cmp_asid);

endmodule

// File: rtl/lm32_itlb_assoc.sv
// Set-associative instruction TLB with CSR-driven maintenance FSM
// (full flush, update, single invalidate, per-ASID flush) and sticky miss.
module lm32_itlb_assoc
  import lm32_itlb_assoc_pkg::*;
#(
  parameter int tlb_sets   = 64,
  parameter int tlb_ways   = 2,
  parameter int page_size  = 4096,
  parameter int asid_width = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  stall_a,
  input  logic                  stall_f,
  input  logic [29:0]           pc_a,
  input  logic [29:0]           pc_f,
  input  logic                  read_enable_f,
  input  logic [4:0]            csr,
  input  logic [31:0]           csr_write_data,
  input  logic                  csr_write_enable,
  input  logic                  tlb_enable,
  input  logic [asid_width-1:0] asid,
  input  logic                  miss_ack,
  output logic [29:0]           physical_pc_f,
  output logic                  itlb_miss,
  output logic                  busy,
  output logic [31:0]           csr_read_data,
  output logic [1:0]            dbg_state
);

  localparam int page_bits = $clog2(page_size);
  localparam int off_w     = page_bits - 2;           // word offset inside a page
  localparam int vpfn_w    = 30 - off_w;
  localparam int pfn_w     = vpfn_w;
  localparam int idx_w     = $clog2(tlb_sets);
  localparam int tag_w     = vpfn_w - idx_w;
  localparam int rr_w      = (tlb_ways > 1) ? $clog2(tlb_ways) : 1;
  localparam logic [rr_w-1:0] RR_MAX = rr_w'(tlb_ways - 1);

  itlb_state_t       state_q, state_d;
  itlb_op_t          op_q, op_d;
  logic [idx_w-1:0]  set_q, set_d;
  logic [vpfn_w-1:0] vaddr_q, vaddr_d;     // vaddr_reg page number, offset bits are zero
  logic [pfn_w-1:0]  paddr_q, paddr_d;     // paddr_reg page number
  logic [rr_w-1:0]   rr_q, rr_d;
  logic              miss_q, miss_d;
  logic [29:0]       miss_addr_q, miss_addr_d;

  logic [tlb_ways-1:0] way_we, way_hit, way_asid_hit, way_valid;
  logic [pfn_w-1:0]    way_pfn [tlb_ways];
  logic [idx_w-1:0]    raddr;
  logic [tag_w-1:0]    cmp_tag;
  logic                w_valid;
  logic                hit_any, inv_any, new_miss;
  logic [rr_w-1:0]     hit_way, inv_way;
  logic [pfn_w-1:0]    hit_pfn;
  logic                unused_bits;

  assign unused_bits = ^{pc_a[29 -: tag_w], pc_a[off_w-1:0], csr_write_data[page_bits-1:4]};

  assign busy      = (state_q != ST_IDLE);
  assign dbg_state = state_q;
  assign cmp_tag   = busy ? vaddr_q[vpfn_w-1:idx_w] : pc_f[29 -: tag_w];

  for (genvar w = 0; w < tlb_ways; w++) begin : g_way
    lm32_itlb_way #(
      .sets(tlb_sets), .idx_w(idx_w), .tag_w(tag_w), .asid_w(asid_width), .pfn_w(pfn_w)
    ) u_way (
      .clk_i    (clk_i),
      .raddr    (raddr),
      .we       (way_we[w]),
      .waddr    (set_q),
      .wvalid   (w_valid),
      .wasid    (asid),
      .wtag     (vaddr_q[vpfn_w-1:idx_w]),
      .wpfn     (paddr_q),
      .cmp_tag  (cmp_tag),
      .cmp_asid (asid),
      .rd_valid (way_valid[w]),
      .rd_pfn   (way_pfn[w]),
      .hit      (way_hit[w]),
      .asid_hit (way_asid_hit[w])
    );
  end

  // RAM read index: pipeline address when it advances, else FSM set or held F index
  always_comb begin
    raddr = pc_f[off_w +: idx_w];
    if (!stall_a || !stall_f) raddr = pc_a[off_w +: idx_w];
    else if (busy)            raddr = set_q;
  end

  // Lowest hitting way and lowest invalid way (descending scan, last match wins)
  always_comb begin
    hit_any = 1'b0;
    hit_way = '0;
    hit_pfn = '0;
    inv_any = 1'b0;
    inv_way = '0;
    for (int w = tlb_ways - 1; w >= 0; w--) begin
      if (way_hit[w]) begin
        hit_any = 1'b1;
        hit_way = w[rr_w-1:0];
        hit_pfn = way_pfn[w];
      end
      if (!way_valid[w]) begin
        inv_any = 1'b1;
        inv_way = w[rr_w-1:0];
      end
    end
  end

  assign physical_pc_f = tlb_enable ? {hit_pfn, pc_f[off_w-1:0]} : pc_f;
  assign new_miss      = tlb_enable && read_enable_f && !hit_any && !busy;
  assign itlb_miss     = miss_q || new_miss;

  // Sticky miss flag: a new miss beats an acknowledge in the same cycle
  always_comb begin
    miss_d      = miss_q;
    miss_addr_d = miss_addr_q;
    if (new_miss) begin
      miss_d      = 1'b1;
      miss_addr_d = pc_f;
    end else if (miss_ack) begin
      miss_d = 1'b0;
    end
  end

  // CSR read mux
  always_comb begin
    csr_read_data = '0;
    if (csr == TLB_VADDRESS)      csr_read_data = {miss_addr_q, 2'b00};
    else if (csr == TLB_PADDRESS) csr_read_data = {31'b0, busy};
  end

  // Maintenance FSM: CSR commands accepted only in IDLE
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    set_d   = set_q;
    vaddr_d = vaddr_q;
    paddr_d = paddr_q;
    rr_d    = rr_q;
    way_we  = '0;
    w_valid = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (csr_write_enable && csr == TLB_VADDRESS) begin
          if (!csr_write_data[0]) begin
            vaddr_d = csr_write_data[31 -: vpfn_w];
          end else begin
            case (csr_write_data[3:1])
              CMD_FLUSH:      begin state_d = ST_FLUSH; set_d = '1; end
              CMD_INVALIDATE: begin state_d = ST_RD; op_d = OP_INVALIDATE; set_d = vaddr_q[idx_w-1:0]; end
              CMD_ASID_FLUSH: begin state_d = ST_RD; op_d = OP_ASID_FLUSH; set_d = '1; end
              default: ;
            endcase
          end
        end else if (csr_write_enable && csr == TLB_PADDRESS) begin
          paddr_d = csr_write_data[31 -: pfn_w];
          state_d = ST_RD;
          op_d    = OP_UPDATE;
          set_d   = vaddr_q[idx_w-1:0];
        end
      end
      ST_FLUSH: begin
        way_we = '1;
        if (set_q == '0) state_d = ST_IDLE;
        else             set_d   = set_q - 1'b1;
      end
      ST_RD: state_d = ST_WR;
      ST_WR: begin
        case (op_q)
          OP_UPDATE: begin
            w_valid = 1'b1;
            if (hit_any)      way_we[hit_way] = 1'b1;
            else if (inv_any) way_we[inv_way] = 1'b1;
            else begin
              way_we[rr_q] = 1'b1;
              rr_d = (rr_q == RR_MAX) ? '0 : rr_q + 1'b1;
            end
          end
          OP_INVALIDATE: if (hit_any) way_we[hit_way] = 1'b1;
          OP_ASID_FLUSH: way_we = way_asid_hit;
          default: ;
        endcase
        if (op_q == OP_ASID_FLUSH && set_q != '0) begin
          set_d   = set_q - 1'b1;
          state_d = ST_RD;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_FLUSH;
    endcase
  end

  // State registers; reset restarts the full flush from the top set
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= ST_FLUSH;
      op_q        <= OP_UPDATE;
      set_q       <= '1;
      vaddr_q     <= '0;
      paddr_q     <= '0;
      rr_q        <= '0;
      miss_q      <= 1'b0;
      miss_addr_q <= '0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      set_q       <= set_d;
      vaddr_q     <= vaddr_d;
      paddr_q     <= paddr_d;
      rr_q        <= rr_d;
      miss_q      <= miss_d;
      miss_addr_q <= miss_addr_d;
    end
  end

endmodule

// File: tb/tb_lm32_itlb_assoc.sv
// Self-checking bench for lm32_itlb_assoc (default parameters: 64 sets, 2 ways, 4 KiB pages).
module tb_lm32_itlb_assoc;
  import lm32_itlb_assoc_pkg::*;

  localparam int SETS = 64;
  localparam int WAYS = 2;

  logic        clk_i = 1'b0;
  logic        rst_i, stall_a, stall_f, read_enable_f, csr_write_enable, tlb_enable, miss_ack;
  logic [29:0] pc_a, pc_f, physical_pc_f;
  logic [4:0]  csr;
  logic [31:0] csr_write_data, csr_read_data;
  logic [7:0]  asid;
  logic        itlb_miss, busy;
  logic [1:0]  dbg_state;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: per-set, per-way entries addressed by byte address
  bit          m_valid [SETS][WAYS];
  int unsigned m_tag   [SETS][WAYS];
  int unsigned m_asid  [SETS][WAYS];
  int unsigned m_pfn   [SETS][WAYS];
  int          m_rr;

  lm32_itlb_assoc dut (
    .clk_i(clk_i), .rst_i(rst_i), .stall_a(stall_a), .stall_f(stall_f),
    .pc_a(pc_a), .pc_f(pc_f), .read_enable_f(read_enable_f),
    .csr(csr), .csr_write_data(csr_write_data), .csr_write_enable(csr_write_enable),
    .tlb_enable(tlb_enable), .asid(asid), .miss_ack(miss_ack),
    .physical_pc_f(physical_pc_f), .itlb_miss(itlb_miss), .busy(busy),
    .csr_read_data(csr_read_data), .dbg_state(dbg_state)
  );

  // Clock
  always #5 clk_i = ~clk_i;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- model ----------------
  task automatic model_reset();
    for (int s = 0; s < SETS; s++)
      for (int w = 0; w < WAYS; w++) m_valid[s][w] = 1'b0;
    m_rr = 0;
  endtask

  task automatic model_update(input logic [31:0] va, input logic [31:0] pa, input int unsigned a);
    int s, v;
    int unsigned t;
    s = int'((va >> 12) % SETS);
    t = va >> 18;
    v = -1;
    for (int w = 0; w < WAYS; w++)
      if (v < 0 && m_valid[s][w] && m_tag[s][w] == t && m_asid[s][w] == a) v = w;
    for (int w = 0; w < WAYS; w++)
      if (v < 0 && !m_valid[s][w]) v = w;
    if (v < 0) begin
      v = m_rr;
      m_rr = (m_rr + 1) % WAYS;
    end
    m_valid[s][v] = 1'b1;
    m_tag[s][v]   = t;
    m_asid[s][v]  = a;
    m_pfn[s][v]   = pa >> 12;
  endtask

  task automatic model_invalidate(input logic [31:0] va, input int unsigned a);
    int s;
    bit done;
    s = int'((va >> 12) % SETS);
    done = 1'b0;
    for (int w = 0; w < WAYS; w++)
      if (!done && m_valid[s][w] && m_tag[s][w] == (va >> 18) && m_asid[s][w] == a) begin
        m_valid[s][w] = 1'b0;
        done = 1'b1;
      end
  endtask

  task automatic model_asid_flush(input int unsigned a);
    for (int s = 0; s < SETS; s++)
      for (int w = 0; w < WAYS; w++)
        if (m_asid[s][w] == a) m_valid[s][w] = 1'b0;
  endtask

  task automatic model_lookup(input logic [31:0] va, input int unsigned a,
                              output bit h, output logic [31:0] phys);
    int s;
    s = int'((va >> 12) % SETS);
    h = 1'b0;
    phys = '0;
    for (int w = WAYS - 1; w >= 0; w--)
      if (m_valid[s][w] && m_tag[s][w] == (va >> 18) && m_asid[s][w] == a) begin
        h = 1'b1;
        phys = (m_pfn[s][w] << 12) | (va & 32'h0000_0FFC);
      end
  endtask

  // ---------------- drivers ----------------
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic csr_wr(input logic [4:0] idx, input logic [31:0] data);
    csr = idx;
    csr_write_data = data;
    csr_write_enable = 1'b1;
    tick();
    csr_write_enable = 1'b0;
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while (busy === 1'b1 && n < 1000) begin
      n++;
      tick();
    end
  endtask

  task automatic do_fetch(input logic [31:0] va, output logic miss, output logic [31:0] phys);
    pc_a = va[31:2];
    stall_a = 1'b0;
    stall_f = 1'b0;
    tick();
    pc_f = va[31:2];
    stall_a = 1'b1;
    stall_f = 1'b1;
    read_enable_f = 1'b1;
    #1;
    miss = itlb_miss;
    phys = {physical_pc_f, 2'b00};
    tick();
    read_enable_f = 1'b0;
    miss_ack = 1'b1;
    tick();
    miss_ack = 1'b0;
  endtask

  task automatic do_update(input logic [31:0] va, input logic [31:0] pa);
    int n;
    csr_wr(TLB_VADDRESS, va);
    csr_wr(TLB_PADDRESS, pa);
    wait_idle(n);
    n_tests++;
    if (n !== 2) begin n_fail++; $display("FAIL update_busy_cycles: got %0d expected 2", n); end
    model_update(va, pa, asid);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    int n;
    logic miss;
    logic [31:0] phys;
    rst_i = 1'b1;
    tlb_enable = 1'b0;
    pc_f = 30'h1234_567;
    tick(); tick(); tick();
    n_tests++;
    if (itlb_miss !== 1'b0) begin n_fail++; $display("FAIL reset_miss: got %0b expected 0", itlb_miss); end
    n_tests++;
    if (busy !== 1'b1) begin n_fail++; $display("FAIL reset_busy: got %0b expected 1", busy); end
    csr = TLB_VADDRESS; #1;
    n_tests++;
    if (csr_read_data !== 32'h0) begin n_fail++; $display("FAIL reset_miss_addr: got %0h expected 0", csr_read_data); end
    csr = TLB_PADDRESS; #1;
    n_tests++;
    if (csr_read_data !== 32'h1) begin n_fail++; $display("FAIL reset_busy_csr: got %0h expected 1", csr_read_data); end
    n_tests++;
    if (physical_pc_f !== 30'h1234_567) begin n_fail++; $display("FAIL reset_passthrough: got %0h expected 1234567", physical_pc_f); end
    rst_i = 1'b0;
    tlb_enable = 1'b1;
    model_reset();
    wait_idle(n);
    n_tests++;
    if (n !== 64) begin n_fail++; $display("FAIL reset_flush_cycles: got %0d expected 64", n); end
    asid = 8'd0;
    do_fetch(32'h0000_1000, miss, phys);
    n_tests++;
    if (miss !== 1'b1) begin n_fail++; $display("FAIL first_fetch_miss: got %0b expected 1", miss); end
    csr = TLB_VADDRESS; #1;
    n_tests++;
    if (csr_read_data !== 32'h0000_1000) begin n_fail++; $display("FAIL first_miss_addr: got %0h expected 1000", csr_read_data); end
  endtask

  task automatic test_update_hit();
    logic miss;
    logic [31:0] phys;
    asid = 8'd3;
    do_update(32'h0000_3000, 32'h8000_5000);
    do_fetch(32'h0000_3ABC, miss, phys);
    n_tests++;
    if (miss !== 1'b0) begin n_fail++; $display("FAIL update_hit_miss: got %0b expected 0", miss); end
    n_tests++;
    if (phys !== 32'h8000_5ABC) begin n_fail++; $display("FAIL update_hit_phys: got %0h expected 80005abc", phys); end
    asid = 8'd4;
    do_fetch(32'h0000_3ABC, miss, phys);
    n_tests++;
    if (miss !== 1'b1) begin n_fail++; $display("FAIL other_asid_miss: got %0b expected 1", miss); end
    asid = 8'd3;
  endtask

  task automatic test_replacement();
    logic miss;
    logic [31:0] phys;
    asid = 8'd3;
    do_update(32'h0000_3000, 32'h8000_5000);
    do_update(32'h0004_3000, 32'h9000_0000);
    do_update(32'h0008_3000, 32'hA000_0000);
    do_fetch(32'h0000_3000, miss, phys);
    n_tests++;
    if (miss !== 1'b1) begin n_fail++; $display("FAIL replaced_entry: got %0b expected 1", miss); end
    do_fetch(32'h0004_3010, miss, phys);
    n_tests++;
    if (miss !== 1'b0 || phys !== 32'h9000_0010) begin
      n_fail++; $display("FAIL kept_way1: got miss=%0b phys=%0h expected miss=0 phys=90000010", miss, phys);
    end
    do_fetch(32'h0008_3020, miss, phys);
    n_tests++;
    if (miss !== 1'b0 || phys !== 32'hA000_0020) begin
      n_fail++; $display("FAIL new_way0: got miss=%0b phys=%0h expected miss=0 phys=a0000020", miss, phys);
    end
  endtask

  task automatic test_invalidate_asid_flush();
    int n;
    logic miss;
    logic [31:0] phys;
    asid = 8'd5;
    do_update(32'h0001_0000, 32'hB001_0000);
    do_update(32'h0001_1000, 32'hB001_1000);
    asid = 8'd3;
    csr_wr(TLB_VADDRESS, 32'h0004_3000);
    csr_wr(TLB_VADDRESS, 32'h0000_0005);
    wait_idle(n);
    model_invalidate(32'h0004_3000, 3);
    n_tests++;
    if (n !== 2) begin n_fail++; $display("FAIL invalidate_cycles: got %0d expected 2", n); end
    do_fetch(32'h0004_3000, miss, phys);
    n_tests++;
    if (miss !== 1'b1) begin n_fail++; $display("FAIL invalidated_entry: got %0b expected 1", miss); end
    do_fetch(32'h0008_3000, miss, phys);
    n_tests++;
    if (miss !== 1'b0) begin n_fail++; $display("FAIL invalidate_neighbour: got %0b expected 0", miss); end
    csr_wr(TLB_VADDRESS, 32'h0000_0007);
    wait_idle(n);
    model_asid_flush(3);
    n_tests++;
    if (n !== 128) begin n_fail++; $display("FAIL asid_flush_cycles: got %0d expected 128", n); end
    do_fetch(32'h0008_3000, miss, phys);
    n_tests++;
    if (miss !== 1'b1) begin n_fail++; $display("FAIL asid3_flushed: got %0b expected 1", miss); end
    asid = 8'd5;
    do_fetch(32'h0001_0000, miss, phys);
    n_tests++;
    if (miss !== 1'b0 || phys !== 32'hB001_0000) begin
      n_fail++; $display("FAIL asid5_kept_a: got miss=%0b phys=%0h expected miss=0 phys=b0010000", miss, phys);
    end
    do_fetch(32'h0001_1000, miss, phys);
    n_tests++;
    if (miss !== 1'b0) begin n_fail++; $display("FAIL asid5_kept_b: got %0b expected 0", miss); end
    asid = 8'd3;
  endtask

  task automatic test_miss_ack_overlap();
    asid = 8'd3;
    pc_a = 30'h0002_0000 >> 2; stall_a = 1'b0; stall_f = 1'b0;
    tick();
    pc_f = 30'h0002_0000 >> 2; stall_a = 1'b1; stall_f = 1'b1; read_enable_f = 1'b1;
    tick();
    read_enable_f = 1'b0;
    tick();
    csr = TLB_VADDRESS; #1;
    n_tests++;
    if (itlb_miss !== 1'b1) begin n_fail++; $display("FAIL miss_sticky: got %0b expected 1", itlb_miss); end
    n_tests++;
    if (csr_read_data !== 32'h0002_0000) begin n_fail++; $display("FAIL miss_addr_first: got %0h expected 20000", csr_read_data); end
    pc_a = 30'h0000_7000 >> 2; stall_a = 1'b0; stall_f = 1'b0;
    tick();
    pc_f = 30'h0000_7000 >> 2; stall_a = 1'b1; stall_f = 1'b1; read_enable_f = 1'b1; miss_ack = 1'b1;
    tick();
    read_enable_f = 1'b0; miss_ack = 1'b0; #1;
    n_tests++;
    if (itlb_miss !== 1'b1) begin n_fail++; $display("FAIL ack_vs_new_miss: got %0b expected 1", itlb_miss); end
    n_tests++;
    if (csr_read_data !== 32'h0000_7000) begin n_fail++; $display("FAIL miss_addr_update: got %0h expected 7000", csr_read_data); end
    miss_ack = 1'b1;
    tick();
    miss_ack = 1'b0; #1;
    n_tests++;
    if (itlb_miss !== 1'b0) begin n_fail++; $display("FAIL miss_cleared: got %0b expected 0", itlb_miss); end
  endtask

  task automatic test_busy_ignore();
    int n;
    logic miss;
    logic [31:0] phys;
    asid = 8'd9;
    csr_wr(TLB_VADDRESS, 32'h0000_0007);
    csr_wr(TLB_VADDRESS, 32'h0000_7000);
    csr_wr(TLB_PADDRESS, 32'hD000_7000);
    csr_wr(TLB_VADDRESS, 32'h0000_0003);
    wait_idle(n);
    model_asid_flush(9);
    n_tests++;
    if (n !== 125) begin n_fail++; $display("FAIL busy_ignore_cycles: got %0d expected 125", n); end
    asid = 8'd5;
    do_fetch(32'h0001_0000, miss, phys);
    n_tests++;
    if (miss !== 1'b0) begin n_fail++; $display("FAIL ignored_flush: got %0b expected 0", miss); end
    asid = 8'd3;
    do_fetch(32'h0000_7000, miss, phys);
    n_tests++;
    if (miss !== 1'b1) begin n_fail++; $display("FAIL ignored_update: got %0b expected 1", miss); end
    // vaddr_reg must still hold the last accepted value 0x00043000
    csr_wr(TLB_PADDRESS, 32'hE000_0000);
    wait_idle(n);
    model_update(32'h0004_3000, 32'hE000_0000, 3);
    do_fetch(32'h0004_3444, miss, phys);
    n_tests++;
    if (miss !== 1'b0 || phys !== 32'hE000_0444) begin
      n_fail++; $display("FAIL ignored_vaddr: got miss=%0b phys=%0h expected miss=0 phys=e0000444", miss, phys);
    end
  endtask

  task automatic test_passthrough();
    tlb_enable = 1'b0;
    asid = 8'd3;
    pc_f = 30'h0000_9000 >> 2;
    read_enable_f = 1'b1;
    #1;
    n_tests++;
    if (physical_pc_f !== (30'h0000_9000 >> 2) || itlb_miss !== 1'b0) begin
      n_fail++; $display("FAIL passthrough: got pc=%0h miss=%0b expected pc=2400 miss=0", physical_pc_f, itlb_miss);
    end
    tick();
    read_enable_f = 1'b0;
    tlb_enable = 1'b1;
  endtask

  task automatic test_random();
    logic miss;
    logic [31:0] phys, exp_phys, va;
    bit h;
    for (int i = 0; i < 16; i++) begin
      va = ($urandom_range(0, 3) << 18) | ($urandom_range(0, 7) << 12);
      asid = ($urandom_range(0, 1) != 0) ? 8'd3 : 8'd5;
      do_update(va, $urandom & 32'hFFFF_F000);
    end
    for (int i = 0; i < 24; i++) begin
      va = ($urandom_range(0, 3) << 18) | ($urandom_range(0, 7) << 12) | ($urandom_range(0, 4095) & 32'hFFC);
      case ($urandom_range(0, 2))
        0: asid = 8'd3;
        1: asid = 8'd5;
        default: asid = 8'd6;
      endcase
      model_lookup(va, asid, h, exp_phys);
      do_fetch(va, miss, phys);
      n_tests++;
      if (miss !== !h) begin n_fail++; $display("FAIL random_miss va=%0h: got %0b expected %0b", va, miss, !h); end
      if (h) begin
        n_tests++;
        if (phys !== exp_phys) begin n_fail++; $display("FAIL random_phys va=%0h: got %0h expected %0h", va, phys, exp_phys); end
      end
    end
  endtask

  task automatic test_reset_mid_asid_flush();
    int n;
    logic miss;
    logic [31:0] phys;
    logic [31:0] q_va[$];
    logic [7:0]  q_as[$];
    for (int s = 0; s < SETS; s++)
      for (int w = 0; w < WAYS; w++)
        if (m_valid[s][w]) begin
          q_va.push_back((m_tag[s][w] << 18) | (s << 12));
          q_as.push_back(8'(m_asid[s][w]));
        end
    asid = 8'd5;
    csr_wr(TLB_VADDRESS, 32'h0000_0007);
    repeat (10) tick();
    rst_i = 1'b1;
    #1;
    n_tests++;
    if (busy !== 1'b1 || itlb_miss !== 1'b0) begin
      n_fail++; $display("FAIL mid_reset_state: got busy=%0b miss=%0b expected busy=1 miss=0", busy, itlb_miss);
    end
    tick();
    rst_i = 1'b0;
    model_reset();
    wait_idle(n);
    n_tests++;
    if (n !== 64) begin n_fail++; $display("FAIL mid_reset_flush_cycles: got %0d expected 64", n); end
    for (int i = 0; i < q_va.size() && i < 12; i++) begin
      asid = q_as[i];
      do_fetch(q_va[i], miss, phys);
      n_tests++;
      if (miss !== 1'b1) begin n_fail++; $display("FAIL mid_reset_entry va=%0h: got %0b expected 1", q_va[i], miss); end
    end
  endtask

  task automatic test_flush_cmd();
    int n;
    logic miss;
    logic [31:0] phys;
    asid = 8'd3;
    do_update(32'h0000_5000, 32'h8000_0000);
    csr_wr(TLB_VADDRESS, 32'h0000_000F);
    #1;
    n_tests++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL unknown_cmd_ignored: got busy=%0b expected 0", busy); end
    do_fetch(32'h0000_5000, miss, phys);
    n_tests++;
    if (miss !== 1'b0) begin n_fail++; $display("FAIL before_flush_hit: got %0b expected 0", miss); end
    csr_wr(TLB_VADDRESS, 32'h0000_0003);
    wait_idle(n);
    n_tests++;
    if (n !== 64) begin n_fail++; $display("FAIL flush_cmd_cycles: got %0d expected 64", n); end
    do_fetch(32'h0000_5000, miss, phys);
    n_tests++;
    if (miss !== 1'b1) begin n_fail++; $display("FAIL after_flush_miss: got %0b expected 1", miss); end
  endtask

  initial begin
    rst_i = 1'b1;
    stall_a = 1'b1;
    stall_f = 1'b1;
    pc_a = '0;
    pc_f = '0;
    read_enable_f = 1'b0;
    csr = '0;
    csr_write_data = '0;
    csr_write_enable = 1'b0;
    tlb_enable = 1'b1;
    asid = '0;
    miss_ack = 1'b0;
    test_reset();
    test_update_hit();
    test_replacement();
    test_invalidate_asid_flush();
    test_miss_ack_overlap();
    test_busy_ignore();
    test_passthrough();
    test_random();
    test_reset_mid_asid_flush();
    test_flush_cmd();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
